// File: rtl/expansion_shiftreg_target_pkg.sv
// Shared types and helpers for the expansion shift-register target.
// The frame classifier lives here so that any block reading a frame's
// bit count and overrun flag reaches the same verdict.
package expansion_shiftreg_target_pkg;

    // Outcome of a frame at the moment the next load strobe arrives.
    typedef enum logic [1:0] {
        FRAME_NONE = 2'd0,  // nothing was clocked in: silent
        FRAME_GOOD = 2'd1,  // exactly one word: publish it
        FRAME_BAD  = 2'd2   // short or overlong: discard and flag
    } frame_result_t;

    // Decide what a load strobe does with the frame collected so far.
    function automatic frame_result_t classify_frame(
        input int   bit_cnt,
        input int   width,
        input logic overrun
    );
        if ((bit_cnt == width) && !overrun) begin
            return FRAME_GOOD;
        end
        if ((bit_cnt != 0) || overrun) begin
            return FRAME_BAD;
        end
        return FRAME_NONE;
    endfunction

endpackage

// File: rtl/expansion_shiftreg_target_if.sv
// Link and parallel-side signals of the expansion shift-register target.
// Link pin names match the pins of the master they face.
interface expansion_shiftreg_target_if #(
    parameter int WIDTH = 8
);
    logic             SHIFT_CLK;    // bit clock from the master
    logic             SHIFT_LOAD;   // frame strobe, active-low, idle high
    logic             SHIFT_DIN;    // serial data from the master
    logic             SHIFT_DOUT;   // serial data back to the master
    logic [WIDTH-1:0] data_in;      // word sent in the next frame
    logic [WIDTH-1:0] data_out;     // last good word received
    logic             frame_valid;  // data_out has just updated
    logic             frame_error;  // a frame was just discarded

    // The target side of the link.
    modport slave (
        input  SHIFT_CLK,
        input  SHIFT_LOAD,
        input  SHIFT_DIN,
        input  data_in,
        output SHIFT_DOUT,
        output data_out,
        output frame_valid,
        output frame_error
    );

    // The driving side: the remote master plus whoever owns data_in.
    modport master (
        output SHIFT_CLK,
        output SHIFT_LOAD,
        output SHIFT_DIN,
        output data_in,
        input  SHIFT_DOUT,
        input  data_out,
        input  frame_valid,
        input  frame_error
    );
endinterface

// File: rtl/expansion_shiftreg_target_sync_edge.sv
// Two-flop synchroniser for one asynchronous link pin, followed by a
// history flop so that rising and falling edges of the synchronised level
// can be flagged for exactly one clk cycle. RESET_VAL is the pin's idle
// level, so leaving reset never manufactures an edge.
module shiftreg_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_hist;

    // Move the pin into the clk domain and remember the previous level.
    // NOTE: every flop here is updated with <= so all three stages sample
    // their inputs from before the edge; with = the pin would ripple
    // straight through the chain in a single cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= RESET_VAL;
            r_sync2 <= RESET_VAL;
            r_hist  <= RESET_VAL;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign o_level = r_sync2;
    assign o_rise  =  r_sync2 & ~r_hist;
    assign o_fall  = ~r_sync2 &  r_hist;

endmodule

// File: rtl/expansion_shiftreg_target.sv
// Slave end of the expansion shift-register link. Stands in for a
// 74HC595/74HC165 pair: bits arrive MSB-first on SHIFT_DIN and are sampled
// on SHIFT_CLK falls; SHIFT_DOUT changes on the same falls so that the
// master can sample it on its next rise. A falling SHIFT_LOAD closes the
// current frame (publish, discard or ignore it) and loads data_in for the
// next one. All link pins are oversampled by clk.
module expansion_shiftreg_target
    import expansion_shiftreg_target_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    expansion_shiftreg_target_if.slave   io_link
);

    // Wide enough to hold WIDTH itself, where the counter saturates.
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    // Synchronised link pins and their edge strobes.
    logic w_clk_level;
    logic w_clk_rise;
    logic w_clk_fall;
    logic w_load_level;
    logic w_load_rise;
    logic w_load_fall;
    logic w_din_level;
    logic w_din_rise_unused;
    logic w_din_fall_unused;

    // Decoded events and the verdict on the frame collected so far.
    logic          w_clk_qrise;
    logic          w_bit_event;
    frame_result_t w_result;

    // Frame state.
    logic [WIDTH-1:0] r_rx_shift;
    logic [WIDTH-1:0] r_tx_shift;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_armed;
    logic             r_overrun;

    // Registered outputs.
    logic             r_dout;
    logic [WIDTH-1:0] r_data_out;
    logic             r_frame_valid;
    logic             r_frame_error;

    // SHIFT_CLK idles low.
    shiftreg_sync_edge #(.RESET_VAL(1'b0)) u_sync_clk (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (io_link.SHIFT_CLK),
        .o_level (w_clk_level),
        .o_rise  (w_clk_rise),
        .o_fall  (w_clk_fall)
    );

    // SHIFT_LOAD idles high; resetting it low would fake a load on release.
    shiftreg_sync_edge #(.RESET_VAL(1'b1)) u_sync_load (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (io_link.SHIFT_LOAD),
        .o_level (w_load_level),
        .o_rise  (w_load_rise),
        .o_fall  (w_load_fall)
    );

    // Only the level of the data pin matters; it is sampled on clock falls.
    shiftreg_sync_edge #(.RESET_VAL(1'b0)) u_sync_din (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (io_link.SHIFT_DIN),
        .o_level (w_din_level),
        .o_rise  (w_din_rise_unused),
        .o_fall  (w_din_fall_unused)
    );

    // A rise only counts when LOAD has been high for this cycle and the
    // previous one (high now and not rising now). This rejects the rise the
    // master produces while releasing LOAD, which carries no data bit.
    assign w_clk_qrise = w_clk_rise & w_load_level & ~w_load_rise;

    // A fall is a data bit only after a qualified rise has armed us.
    assign w_bit_event = w_clk_fall & r_armed;

    assign w_result = classify_frame(int'(r_bit_cnt), WIDTH, r_overrun);

    // Frame control: load closes and reloads a frame, qualified rises arm,
    // armed falls shift one bit. Load takes priority over any clock edge
    // seen in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_shift    <= '0;
            r_tx_shift    <= '0;
            r_bit_cnt     <= '0;
            r_armed       <= 1'b0;
            r_overrun     <= 1'b0;
            r_dout        <= 1'b0;
            r_data_out    <= '0;
            r_frame_valid <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_frame_error <= 1'b0;

            if (w_load_fall) begin
                case (w_result)
                    FRAME_GOOD: begin
                        r_data_out    <= r_rx_shift;
                        r_frame_valid <= 1'b1;
                    end
                    FRAME_BAD: begin
                        r_frame_error <= 1'b1;
                    end
                    default: begin
                    end
                endcase
                r_tx_shift <= io_link.data_in;
                r_dout     <= io_link.data_in[WIDTH-1];
                r_bit_cnt  <= '0;
                r_overrun  <= 1'b0;
                r_armed    <= 1'b0;
            end else if (w_clk_qrise) begin
                r_armed <= 1'b1;
            end else if (w_bit_event) begin
                r_armed <= 1'b0;
                if (r_bit_cnt < CNT_FULL) begin
                    r_rx_shift <= {r_rx_shift[WIDTH-2:0], w_din_level};
                    r_tx_shift <= r_tx_shift << 1;
                    r_dout     <= r_tx_shift[WIDTH-2];
                    r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
                end else begin
                    // Extra bits beyond WIDTH poison the frame but leave
                    // the shift registers and SHIFT_DOUT where they are.
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    // The clock level itself is only needed for edge detection.
    logic w_clk_level_unused;
    assign w_clk_level_unused = w_clk_level;

    assign io_link.SHIFT_DOUT  = r_dout;
    assign io_link.data_out    = r_data_out;
    assign io_link.frame_valid = r_frame_valid;
    assign io_link.frame_error = r_frame_error;

endmodule

// File: tb/tb_expansion_shiftreg_target.sv
// Directed bench for expansion_shiftreg_target. A master model drives
// SHIFT_CLK at clk/16; expected frame outcomes go into a scoreboard queue
// when the bits are sent and are popped when the DUT pulses.
module tb_expansion_shiftreg_target;

    localparam int W    = 8;
    localparam int HALF = 8;   // clk cycles per half SHIFT_CLK period

    typedef enum {EV_VALID, EV_ERROR} ev_kind_t;
    typedef struct {
        ev_kind_t     kind;
        logic [W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    expansion_shiftreg_target_if #(.WIDTH(W)) link();

    expansion_shiftreg_target #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .io_link (link)
    );

    exp_t         sb[$];
    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] model_out = '0;   // what data_out should currently hold
    logic [W-1:0] got;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Load strobe; optionally raise SHIFT_CLK together with the release.
    task automatic pulse_load(input bit with_rise);
        link.SHIFT_LOAD = 1'b0;
        tick(HALF);
        link.SHIFT_LOAD = 1'b1;
        if (with_rise) link.SHIFT_CLK = 1'b1;
        tick(HALF);
        if (with_rise) begin
            link.SHIFT_CLK = 1'b0;
            tick(HALF);
        end
    endtask

    // One bit: master drives data and samples SHIFT_DOUT on the rise.
    task automatic send_bit(input logic b, output logic sampled);
        link.SHIFT_CLK = 1'b1;
        link.SHIFT_DIN = b;
        sampled        = link.SHIFT_DOUT;
        tick(HALF);
        link.SHIFT_CLK = 1'b0;
        tick(HALF);
    endtask

    // Clock nbits of word MSB-first and record the expected frame outcome.
    task automatic send_word(input logic [W-1:0] word, input int nbits, output logic [W-1:0] rx);
        logic b;
        logic s;
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            b = (i < W) ? word[W-1-i] : 1'b0;
            send_bit(b, s);
            if (i < W) rx = {rx[W-2:0], s};
        end
        if (nbits == W) begin
            model_out = word;
            sb.push_back('{EV_VALID, word});
        end else if (nbits != 0) begin
            sb.push_back('{EV_ERROR, model_out});
        end
    endtask

    task automatic run_frame(input logic [W-1:0] word, input int nbits,
                             input logic [W-1:0] din, output logic [W-1:0] rx);
        link.data_in = din;
        pulse_load(1'b0);
        send_word(word, nbits, rx);
    endtask

    // Pops one expectation for every pulse the DUT produces.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (link.frame_valid || link.frame_error) begin
                check("pulse_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("pulse_valid", 32'(link.frame_valid), 32'(e.kind == EV_VALID));
                    check("pulse_error", 32'(link.frame_error), 32'(e.kind == EV_ERROR));
                    check("pulse_data_out", 32'(link.data_out), 32'(e.data));
                end
            end
        end
    endtask

    initial begin
        link.SHIFT_CLK  = 1'b0;
        link.SHIFT_LOAD = 1'b1;
        link.SHIFT_DIN  = 1'b0;
        link.data_in    = '0;
        fork
            monitor();
        join_none

        // Reset state.
        tick(3);
        check("rst_dout", 32'(link.SHIFT_DOUT), 32'd0);
        check("rst_data_out", 32'(link.data_out), 32'd0);
        check("rst_valid", 32'(link.frame_valid), 32'd0);
        check("rst_error", 32'(link.frame_error), 32'd0);
        rst = 1'b0;
        tick(4);

        // Single frame.
        run_frame(8'hA5, 8, 8'h3C, got);
        check("single_master_rx", 32'(got), 32'h3C);
        pulse_load(1'b0);
        check("single_data_out", 32'(link.data_out), 32'hA5);
        check("single_drained", 32'(sb.size()), 32'd0);

        // Back-to-back frames.
        run_frame(8'h01, 8, 8'hFF, got);
        check("b2b_master_rx0", 32'(got), 32'hFF);
        run_frame(8'h80, 8, 8'h00, got);
        check("b2b_master_rx1", 32'(got), 32'h00);
        pulse_load(1'b0);
        check("b2b_data_out", 32'(link.data_out), 32'h80);

        // Short frame.
        run_frame(8'hF0, 5, 8'h00, got);
        pulse_load(1'b0);
        check("short_data_out", 32'(link.data_out), 32'h80);
        check("short_drained", 32'(sb.size()), 32'd0);

        // Overrun, then a good frame.
        run_frame(8'hFF, 10, 8'h00, got);
        run_frame(8'h5A, 8, 8'h11, got);
        check("ovr_master_rx", 32'(got), 32'h11);
        pulse_load(1'b0);
        check("ovr_data_out", 32'(link.data_out), 32'h5A);

        // Release-edge rejection.
        link.data_in = 8'hC3;
        pulse_load(1'b1);
        check("rel_bit_cnt", 32'(dut.r_bit_cnt), 32'd0);
        send_word(8'h96, 8, got);
        check("rel_master_rx", 32'(got), 32'hC3);
        pulse_load(1'b0);
        check("rel_data_out", 32'(link.data_out), 32'h96);

        // Async reset mid-frame.
        link.data_in = 8'hFF;
        pulse_load(1'b0);
        for (int i = 0; i < 4; i++) begin
            logic s;
            send_bit(1'b1, s);
        end
        rst = 1'b1;
        #1;
        check("arst_dout", 32'(link.SHIFT_DOUT), 32'd0);
        check("arst_data_out", 32'(link.data_out), 32'd0);
        check("arst_valid", 32'(link.frame_valid), 32'd0);
        check("arst_error", 32'(link.frame_error), 32'd0);
        model_out = '0;
        tick(3);
        rst = 1'b0;
        tick(4);
        run_frame(8'hE7, 8, 8'h4B, got);
        check("arst_master_rx", 32'(got), 32'h4B);
        pulse_load(1'b0);
        check("arst_data_out_after", 32'(link.data_out), 32'hE7);

        tick(20);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
